// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and requester indices for the register bank write path
package regfile_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;
  localparam int NUM_REQ  = 3;
  localparam int REQ_ALU  = 0;
  localparam int REQ_MEM  = 1;
  localparam int REQ_IMM  = 2;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req[N], ptr (search start) in, one-hot grant out
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  int   idx;
  logic found;
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: RR-shares the bank write port (reqValid/reqRd/reqData -> reqGrant, registered rd/Datain/registerLoad) and tracks pending writes in busy, set by reserveValid/reserveRd
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ  = regfile_pkg::NUM_REQ,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  logic [NUM_REQ*ADDR_W-1:0] reqRd,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  output logic [NUM_REQ-1:0]        reqGrant,
  input  logic                      reserveValid,
  input  logic [ADDR_W-1:0]         reserveRd,
  output logic [ADDR_W-1:0]         rd,
  output logic [DATA_W-1:0]         Datain,
  output logic                      registerLoad,
  output logic [NUM_REGS-1:0]       busy
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                load_q, load_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req  (reqValid),
    .ptr  (ptr_q),
    .grant(grant)
  );
  assign reqGrant = rst ? '0 : grant;
  always_comb begin
    load_d = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    ptr_d  = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reqGrant[i]) begin
        load_d = 1'b1;
        rd_d   = reqRd[i*ADDR_W +: ADDR_W];
        data_d = reqData[i*DATA_W +: DATA_W];
        ptr_d  = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
      end
    end
    busy_d = busy_q;
    if (load_d) busy_d[rd_d] = 1'b0;
    if (reserveValid) busy_d[reserveRd] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      rd_q   <= '0;
      data_q <= '0;
      load_q <= 1'b0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      load_q <= load_d;
      busy_q <= busy_d;
    end
  end
  assign rd           = rd_q;
  assign Datain       = data_q;
  assign registerLoad = load_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenario bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  import regfile_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  reqValid;
  logic [8:0]  reqRd;
  logic [47:0] reqData;
  logic [2:0]  reqGrant;
  logic        reserveValid;
  logic [2:0]  reserveRd;
  logic [2:0]  rd;
  logic [15:0] Datain;
  logic        registerLoad;
  logic [7:0]  busy;
  int checks = 0;
  int failures = 0;
  regfile_write_arbiter dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqRd(reqRd), .reqData(reqData),
    .reqGrant(reqGrant), .reserveValid(reserveValid), .reserveRd(reserveRd),
    .rd(rd), .Datain(Datain), .registerLoad(registerLoad), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; reqValid = '0; reqRd = '0; reqData = '0; reserveValid = 1'b0; reserveRd = '0;
    tick();
    reqValid = 3'b111;
    #1;
    checks++; if (reqGrant !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b exp=000", reqGrant); end
    tick();
    rst = 1'b0; reqValid = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({registerLoad, rd, Datain, busy, reqGrant} !== 31'd0)
        begin failures++; $display("FAIL idle c=%0d got load=%b rd=%0d data=%h busy=%h grant=%b exp all 0", c, registerLoad, rd, Datain, busy, reqGrant); end
      tick();
    end
  endtask
  task automatic test_single_write();
    reqValid = 3'b001; reqRd[0 +: 3] = 3'd5; reqData[0 +: 16] = 16'hABCD;
    #1;
    checks++; if (reqGrant !== 3'b001) begin failures++; $display("FAIL single_grant got=%b exp=001", reqGrant); end
    tick();
    reqValid = '0;
    checks++; if ({registerLoad, rd, Datain} !== {1'b1, 3'd5, 16'hABCD})
      begin failures++; $display("FAIL single_write got load=%b rd=%0d data=%h exp 1/5/abcd", registerLoad, rd, Datain); end
    tick();
    checks++; if ({registerLoad, rd, Datain} !== {1'b0, 3'd5, 16'hABCD})
      begin failures++; $display("FAIL single_hold got load=%b rd=%0d data=%h exp 0/5/abcd", registerLoad, rd, Datain); end
  endtask
  task automatic test_round_robin();
    logic [2:0]  exp_g;
    logic [2:0]  exp_rd;
    logic [15:0] exp_d;
    int cnt [3];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = '{0, 0, 0};
    reqRd = {3'd4, 3'd2, 3'd1};
    reqData = {16'h3333, 16'h2222, 16'h1111};
    reqValid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      exp_g  = 3'b001 << (c % 3);
      exp_rd = (c % 3 == 0) ? 3'd1 : (c % 3 == 1) ? 3'd2 : 3'd4;
      exp_d  = (c % 3 == 0) ? 16'h1111 : (c % 3 == 1) ? 16'h2222 : 16'h3333;
      #1;
      checks++; if (reqGrant !== exp_g) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, reqGrant, exp_g); end
      for (int i = 0; i < 3; i++) if (reqGrant[i]) cnt[i]++;
      tick();
      checks++; if ({registerLoad, rd, Datain} !== {1'b1, exp_rd, exp_d})
        begin failures++; $display("FAIL rr_write c=%0d got load=%b rd=%0d data=%h exp 1/%0d/%h", c, registerLoad, rd, Datain, exp_rd, exp_d); end
    end
    reqValid = '0;
    checks++; if (cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 2)
      begin failures++; $display("FAIL rr_counts got=%0d,%0d,%0d exp=2,2,2", cnt[0], cnt[1], cnt[2]); end
    tick();
  endtask
  task automatic test_scoreboard();
    reserveValid = 1'b1; reserveRd = 3'd3;
    tick();
    reserveValid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++; if (busy !== 8'h08) begin failures++; $display("FAIL sb_busy t+%0d got=%h exp=08", c, busy); end
      tick();
    end
    reqValid = 3'b010; reqRd[REQ_MEM*3 +: 3] = 3'd3; reqData[REQ_MEM*16 +: 16] = 16'hBEEF;
    #1;
    checks++; if (reqGrant !== 3'b010 || busy !== 8'h08) begin failures++; $display("FAIL sb_grant got grant=%b busy=%h exp 010/08", reqGrant, busy); end
    tick();
    reqValid = '0;
    checks++; if ({busy, registerLoad, rd, Datain} !== {8'h00, 1'b1, 3'd3, 16'hBEEF})
      begin failures++; $display("FAIL sb_clear got busy=%h load=%b rd=%0d data=%h exp 00/1/3/beef", busy, registerLoad, rd, Datain); end
  endtask
  task automatic test_collision();
    reserveValid = 1'b1; reserveRd = 3'd2;
    tick();
    reserveValid = 1'b0;
    checks++; if (busy !== 8'h04) begin failures++; $display("FAIL col_reserve got=%h exp=04", busy); end
    reqValid = 3'b100; reqRd[REQ_IMM*3 +: 3] = 3'd2; reqData[REQ_IMM*16 +: 16] = 16'h1234;
    reserveValid = 1'b1; reserveRd = 3'd2;
    #1;
    checks++; if (reqGrant !== 3'b100) begin failures++; $display("FAIL col_grant got=%b exp=100", reqGrant); end
    tick();
    reqValid = '0; reserveValid = 1'b0;
    checks++; if ({busy, registerLoad, rd, Datain} !== {8'h04, 1'b1, 3'd2, 16'h1234})
      begin failures++; $display("FAIL col_setwins got busy=%h load=%b rd=%0d data=%h exp 04/1/2/1234", busy, registerLoad, rd, Datain); end
    reqValid = 3'b010; reqRd[REQ_MEM*3 +: 3] = 3'd6; reqData[REQ_MEM*16 +: 16] = 16'h0F0F;
    tick();
    reqValid = '0;
    checks++; if ({busy, registerLoad, rd, Datain} !== {8'h04, 1'b1, 3'd6, 16'h0F0F})
      begin failures++; $display("FAIL col_untracked got busy=%h load=%b rd=%0d data=%h exp 04/1/6/0f0f", busy, registerLoad, rd, Datain); end
    reqValid = 3'b001; reqRd[REQ_ALU*3 +: 3] = 3'd2; reqData[REQ_ALU*16 +: 16] = 16'h5A5A;
    #1;
    checks++; if (reqGrant !== 3'b001) begin failures++; $display("FAIL col_alu_grant got=%b exp=001", reqGrant); end
    tick();
    reqValid = '0;
    checks++; if ({busy, registerLoad, rd, Datain} !== {8'h00, 1'b1, 3'd2, 16'h5A5A})
      begin failures++; $display("FAIL col_clear got busy=%h load=%b rd=%0d data=%h exp 00/1/2/5a5a", busy, registerLoad, rd, Datain); end
  endtask
  task automatic test_reset_mid();
    reserveValid = 1'b1; reserveRd = 3'd5;
    tick();
    reserveValid = 1'b0;
    checks++; if (busy !== 8'h20) begin failures++; $display("FAIL rm_reserve got=%h exp=20", busy); end
    reqRd = {3'd7, 3'd0, 3'd1};
    reqData = {16'h7777, 16'h0000, 16'hAAAA};
    reqValid = 3'b001;
    #1;
    checks++; if (reqGrant !== 3'b001) begin failures++; $display("FAIL rm_alu_grant got=%b exp=001", reqGrant); end
    tick();
    rst = 1'b1; reqValid = 3'b101;
    #1;
    checks++; if ({reqGrant, registerLoad, rd, Datain} !== {3'b000, 1'b1, 3'd1, 16'hAAAA})
      begin failures++; $display("FAIL rm_in_reset got grant=%b load=%b rd=%0d data=%h exp 000/1/1/aaaa", reqGrant, registerLoad, rd, Datain); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if ({registerLoad, rd, Datain, busy, reqGrant} !== {1'b0, 3'd0, 16'h0000, 8'h00, 3'b001})
      begin failures++; $display("FAIL rm_after got load=%b rd=%0d data=%h busy=%h grant=%b exp 0/0/0000/00/001", registerLoad, rd, Datain, busy, reqGrant); end
    tick();
    #1;
    checks++; if ({registerLoad, rd, Datain, reqGrant} !== {1'b1, 3'd1, 16'hAAAA, 3'b100})
      begin failures++; $display("FAIL rm_retry got load=%b rd=%0d data=%h grant=%b exp 1/1/aaaa/100", registerLoad, rd, Datain, reqGrant); end
    reqValid = '0;
    tick();
  endtask
  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_scoreboard();
    test_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
